hub75_framebuffer: RTL and testbench

Double-buffered pixel store feeding the 64x64 HUB75 panel scanner. The CPU bus side writes 18-bit RGB (6 bits per channel) pixels into the back buffer. The scanner side reads the front buffer as top/bottom pixel pairs, one pair per cycle. Buffer swaps are deferred to the scanner's end-of-frame pulse, so a frame is never displayed half-updated.

---
 rtl/hub75_framebuffer.sv | 198 +++++++++++++++++++
 tb/tb_hub75_framebuffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_framebuffer.sv
// Double-buffered 64x64 HUB75 pixel store: bus writes hit the back bank, the scanner reads top/bottom pairs
// from the front bank, and swaps wait for frame_done. Define FB_FILL_EN to build the hardware fill engine.
module hub75_framebuffer #(
    parameter  int NUM_COLS   = 64,
    parameter  int NUM_ROWS   = 64,
    parameter  int BIT_DEPTH  = 6,
    localparam int NUM_PIXELS = NUM_COLS * NUM_ROWS,
    localparam int HALF       = NUM_PIXELS / 2,
    localparam int AW         = $clog2(NUM_PIXELS),
    localparam int HW         = AW - 1,
    localparam int PW         = 3 * BIT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_data,
    input  logic          swap_req,
    output logic          swap_pending,
    input  logic          frame_done,
    output logic          front_sel,
    input  logic [HW-1:0] rd_pixel,
    output logic [PW-1:0] rd_top,
    output logic [PW-1:0] rd_bot,
    input  logic          fill_start,
    input  logic [PW-1:0] fill_color,
    output logic          fill_busy
);

    // Index {bank, offset}; lo holds the top half of the panel, hi the bottom half.
    logic [PW-1:0] mem_lo [0:2*HALF-1];
    logic [PW-1:0] mem_hi [0:2*HALF-1];

    logic          front_sel_r;
    logic          swap_pending_r;
    logic [PW-1:0] rd_top_r;
    logic [PW-1:0] rd_bot_r;
    logic          busy_s;
    logic          swap_now_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [PW-1:0] wdata_s;

`ifdef FB_FILL_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    localparam logic [AW-1:0] LAST_CNT = AW'(NUM_PIXELS - 1);

    fill_state_t   state_r;
    fill_state_t   state_s;
    logic [AW-1:0] cnt_r;
    logic [PW-1:0] color_r;
    logic          fill_busy_r;
    logic          wr_ready_r;
    logic          fill_we_s;
    logic          fill_load_s;

    // Fill FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fill FSM next-state logic; fill_start is ignored while already filling.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) state_s = ST_FILL;
                else            state_s = ST_IDLE;
            end
            ST_FILL: begin
                if (cnt_r == LAST_CNT) state_s = ST_IDLE;
                else                   state_s = ST_FILL;
            end
            default: state_s = ST_IDLE;
        end
    end

    // Fill FSM outputs: write strobe while filling, counter/colour load on start.
    always_comb begin
        fill_we_s   = 1'b0;
        fill_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) fill_load_s = 1'b1;
                else            fill_load_s = 1'b0;
            end
            ST_FILL: fill_we_s = 1'b1;
            default: begin
                fill_we_s   = 1'b0;
                fill_load_s = 1'b0;
            end
        endcase
    end

    // Fill datapath plus registered busy/ready, tracking the next FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {AW{1'b0}};
            color_r     <= {PW{1'b0}};
            fill_busy_r <= 1'b0;
            wr_ready_r  <= 1'b1;
        end else begin
            fill_busy_r <= (state_s == ST_FILL);
            wr_ready_r  <= (state_s != ST_FILL);
            if (fill_load_s) begin
                cnt_r   <= {AW{1'b0}};
                color_r <= fill_color;
            end else if (fill_we_s) begin
                cnt_r   <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Write source mux: the fill engine owns the write port while busy.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = wr_addr;
        wdata_s = wr_data;
        if (fill_we_s) begin
            we_s    = 1'b1;
            waddr_s = cnt_r;
            wdata_s = color_r;
        end else begin
            we_s    = wr_valid & wr_ready_r;
            waddr_s = wr_addr;
            wdata_s = wr_data;
        end
    end

    assign busy_s    = fill_busy_r;
    assign fill_busy = fill_busy_r;
    assign wr_ready  = wr_ready_r;
`else
    logic unused_fill_s;
    assign unused_fill_s = ^{fill_start, fill_color};

    // Bus is the only write source.
    always_comb begin
        we_s    = wr_valid;
        waddr_s = wr_addr;
        wdata_s = wr_data;
    end

    assign busy_s    = 1'b0;
    assign fill_busy = 1'b0;
    assign wr_ready  = 1'b1;
`endif

    // A request arriving with frame_done swaps at that same edge.
    assign swap_now_s = (swap_pending_r | swap_req) & frame_done & ~busy_s;

    // Swap bookkeeping: front bank select and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel_r    <= 1'b0;
            swap_pending_r <= 1'b0;
        end else if (swap_now_s) begin
            front_sel_r    <= ~front_sel_r;
            swap_pending_r <= 1'b0;
        end else if (swap_req) begin
            swap_pending_r <= 1'b1;
        end
    end

    // Back-bank write port; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            if (waddr_s[AW-1]) mem_hi[{~front_sel_r, waddr_s[HW-1:0]}] <= wdata_s;
            else               mem_lo[{~front_sel_r, waddr_s[HW-1:0]}] <= wdata_s;
        end
    end

    // Scanner read port: one top/bottom pair per cycle from the front bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_top_r <= {PW{1'b0}};
            rd_bot_r <= {PW{1'b0}};
        end else begin
            rd_top_r <= mem_lo[{front_sel_r, rd_pixel}];
            rd_bot_r <= mem_hi[{front_sel_r, rd_pixel}];
        end
    end

    assign front_sel    = front_sel_r;
    assign swap_pending = swap_pending_r;
    assign rd_top       = rd_top_r;
    assign rd_bot       = rd_bot_r;

endmodule

// File: tb/tb_hub75_framebuffer.sv
// Directed self-checking bench for hub75_framebuffer; fill-engine steps are built when FB_FILL_EN is defined.
module tb_hub75_framebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [17:0] wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic        frame_done;
    logic        front_sel;
    logic [10:0] rd_pixel;
    logic [17:0] rd_top;
    logic [17:0] rd_bot;
    logic        fill_start;
    logic [17:0] fill_color;
    logic        fill_busy;

    int tests = 0;
    int fails = 0;

    hub75_framebuffer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_pending(swap_pending),
        .frame_done  (frame_done),
        .front_sel   (front_sel),
        .rd_pixel    (rd_pixel),
        .rd_top      (rd_top),
        .rd_bot      (rd_bot),
        .fill_start  (fill_start),
        .fill_color  (fill_color),
        .fill_busy   (fill_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [17:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int busy_cycles;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = 12'd0; wr_data = 18'd0;
        swap_req = 1'b0; frame_done = 1'b0; rd_pixel = 11'd0;
        fill_start = 1'b0; fill_color = 18'd0;
        #1;
        chk("rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("rst_swap_pending", {31'd0, swap_pending}, 32'd0);
        chk("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_rd_top", {14'd0, rd_top}, 32'd0);
        chk("rst_rd_bot", {14'd0, rd_bot}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Back bank is 1: fill two pixel pairs.
        bus_write(12'd0, 18'h3F000);
        bus_write(12'd2048, 18'h00FC0);
        bus_write(12'd2047, 18'h12345);
        bus_write(12'd4095, 18'h3FFFF);

        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("pending_set", {31'd0, swap_pending}, 32'd1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (front_sel !== 1'b0 || swap_pending !== 1'b1) bad++;
        end
        chk("no_swap_without_frame_done", bad, 32'd0);

        frame_done = 1'b1;
        rd_pixel   = 11'd0;
        tick();
        frame_done = 1'b0;
        chk("swap_front_sel", {31'd0, front_sel}, 32'd1);
        chk("swap_pending_clr", {31'd0, swap_pending}, 32'd0);
        tick();
        chk("read0_top", {14'd0, rd_top}, 32'h3F000);
        chk("read0_bot", {14'd0, rd_bot}, 32'h00FC0);

        // Back bank is now 0: new writes must stay invisible until a swap.
        bus_write(12'd0, 18'h00015);
        bus_write(12'd2048, 18'h2A000);
        tick();
        chk("write_not_visible", {14'd0, rd_top}, 32'h3F000);

        rd_pixel = 11'd2047;
        tick();
        chk("read2047_top", {14'd0, rd_top}, 32'h12345);
        chk("read2047_bot", {14'd0, rd_bot}, 32'h3FFFF);

        swap_req   = 1'b1;
        frame_done = 1'b1;
        rd_pixel   = 11'd0;
        tick();
        swap_req   = 1'b0;
        frame_done = 1'b0;
        chk("same_cycle_front_sel", {31'd0, front_sel}, 32'd0);
        chk("same_cycle_pending", {31'd0, swap_pending}, 32'd0);
        tick();
        chk("bank0_top", {14'd0, rd_top}, 32'h00015);
        chk("bank0_bot", {14'd0, rd_bot}, 32'h2A000);

        // Repeated request while pending yields a single swap.
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        chk("double_req_pending", {31'd0, swap_pending}, 32'd1);
        chk("double_req_front", {31'd0, front_sel}, 32'd0);
        frame_done = 1'b1; tick();
        chk("double_req_swap", {31'd0, front_sel}, 32'd1);
        chk("double_req_clr", {31'd0, swap_pending}, 32'd0);
        tick();
        frame_done = 1'b0;
        chk("no_extra_swap", {31'd0, front_sel}, 32'd1);

`ifdef FB_FILL_EN
        // Fill back bank 0 with 3; a held bus write must wait for the fill.
        fill_start = 1'b1;
        fill_color = 18'h00003;
        tick();
        fill_start = 1'b0;
        fill_color = 18'h3FFFF;
        wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 18'h2AAAA;
        busy_cycles = 0;
        bad = 0;
        for (int i = 0; i < 5000 && fill_busy === 1'b1; i++) begin
            busy_cycles++;
            if (wr_ready !== 1'b0) bad++;
            tick();
        end
        chk("fill_busy_cycles", busy_cycles, 32'd4096);
        chk("fill_wr_ready_low", bad, 32'd0);
        chk("fill_wr_ready_back", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;

        swap_req = 1'b1; frame_done = 1'b1; tick();
        swap_req = 1'b0; frame_done = 1'b0;
        chk("fill_swap_front", {31'd0, front_sel}, 32'd0);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            rd_pixel = 11'(i);
            tick();
            if (rd_top !== ((i == 5) ? 18'h2AAAA : 18'h00003) || rd_bot !== 18'h00003) bad++;
        end
        chk("fill_readback", bad, 32'd0);

        // frame_done during a fill is missed; the next one swaps.
        fill_start = 1'b1; fill_color = 18'h0ABCD; tick(); fill_start = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        chk("fd_in_fill_front", {31'd0, front_sel}, 32'd0);
        chk("fd_in_fill_pending", {31'd0, swap_pending}, 32'd1);
        for (int i = 0; i < 5000 && fill_busy === 1'b1; i++) tick();
        chk("fill2_done", {31'd0, fill_busy}, 32'd0);
        chk("fill2_still_pending", {31'd0, front_sel}, 32'd0);
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        chk("fd_after_fill_swap", {31'd0, front_sel}, 32'd1);
        chk("fd_after_fill_clr", {31'd0, swap_pending}, 32'd0);

        // Reset after 100 fill writes into back bank 0.
        fill_start = 1'b1; fill_color = 18'h15555; tick(); fill_start = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        reset = 1'b1;
        #1;
        chk("midfill_rst_busy", {31'd0, fill_busy}, 32'd0);
        chk("midfill_rst_front", {31'd0, front_sel}, 32'd0);
        chk("midfill_rst_pending", {31'd0, swap_pending}, 32'd0);
        chk("midfill_rst_rd_top", {14'd0, rd_top}, 32'd0);
        chk("midfill_rst_rd_bot", {14'd0, rd_bot}, 32'd0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            rd_pixel = 11'(i);
            tick();
            if (rd_top !== 18'h15555) bad++;
        end
        chk("midfill_words_written", bad, 32'd0);
        rd_pixel = 11'd100;
        tick();
        chk("midfill_word100_old", {14'd0, rd_top}, 32'h00003);
`else
        fill_start = 1'b1;
        fill_color = 18'h00003;
        tick();
        fill_start = 1'b0;
        chk("nofill_busy", {31'd0, fill_busy}, 32'd0);
        chk("nofill_ready", {31'd0, wr_ready}, 32'd1);
        busy_cycles = 0;
        bad = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
